// File: rtl/ram_pkg.sv
// Shared constants and types for the 16x8 dual-port scratch RAM.
package ram_pkg;

    localparam int RAM_DATA_W = 8;
    localparam int RAM_ADDR_W = 4;

    typedef logic [RAM_ADDR_W-1:0] ram_addr_t;
    typedef logic [RAM_DATA_W-1:0] ram_data_t;

endpackage

// File: rtl/ram_bypass_mux.sv
// Port-2 read-data select: forwards the port-1 write data when both ports hit the same word.
module ram_bypass_mux
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              wen,
    input  logic [ADDR_W-1:0] add1,
    input  logic [ADDR_W-1:0] add2,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = mem_data;
        if (wen && (add1 == add2)) begin
            rd_data = din;
        end
    end

endmodule

// File: rtl/ram.sv
// Synchronous dual-port RAM: port 1 read/write (write-first), port 2 read-only with
// write-first bypass on address collision. Both read ports have one clock of latency.
module ram
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] do1,
    output logic [DATA_W-1:0] do2,
    input  logic [ADDR_W-1:0] add1,
    input  logic [ADDR_W-1:0] add2,
    input  logic [DATA_W-1:0] din,
    input  logic              wen,
    input  logic              en
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd2;
    logic [DATA_W-1:0] do2_next;

    assign mem_rd2 = mem[add2];

    ram_bypass_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bypass (
        .wen      (wen),
        .add1     (add1),
        .add2     (add2),
        .din      (din),
        .mem_data (mem_rd2),
        .rd_data  (do2_next)
    );

    // NOTE: the array is built from flops rather than a RAM macro because every word
    // must clear in a single reset cycle; all state here updates with <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            do1 <= '0;
            do2 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            if (wen) begin
                mem[add1] <= din;
                do1       <= din;
            end else begin
                do1 <= mem[add1];
            end
            do2 <= do2_next;
        end
    end

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed test-plan sequences plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_ram;
    import ram_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      en  = 1'b0;
    logic      wen = 1'b0;
    ram_addr_t add1 = '0;
    ram_addr_t add2 = '0;
    ram_data_t din  = '0;
    ram_data_t do1;
    ram_data_t do2;

    int checks = 0;
    int errors = 0;

    ram_data_t model_mem [16];
    ram_data_t exp1 = '0;
    ram_data_t exp2 = '0;

    ram dut (
        .clk  (clk),
        .rst  (rst),
        .do1  (do1),
        .do2  (do2),
        .add1 (add1),
        .add2 (add2),
        .din  (din),
        .wen  (wen),
        .en   (en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input ram_data_t got, input ram_data_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference behaviour: reset clears everything, a disabled cycle changes nothing,
    // otherwise both ports see the written word when they address it this cycle.
    task automatic model_step(input logic r, input logic e, input logic w,
                              input ram_addr_t a1, input ram_addr_t a2, input ram_data_t d);
        if (r) begin
            exp1 = '0;
            exp2 = '0;
            foreach (model_mem[i]) model_mem[i] = '0;
        end else if (e) begin
            exp1 = w ? d : model_mem[a1];
            exp2 = (w && a1 == a2) ? d : model_mem[a2];
            if (w) model_mem[a1] = d;
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cycle(input logic r, input logic e, input logic w,
                         input ram_addr_t a1, input ram_addr_t a2, input ram_data_t d);
        @(negedge clk);
        rst  = r;
        en   = e;
        wen  = w;
        add1 = a1;
        add2 = a2;
        din  = d;
        @(posedge clk);
        #1;
        model_step(r, e, w, a1, a2, d);
        check("do1_model", do1, exp1);
        check("do2_model", do2, exp2);
    endtask

    initial begin
        // Reset for two cycles while a write is being attempted.
        cycle(1, 1, 1, 4'd3, 4'd3, 8'hFF);
        cycle(1, 1, 1, 4'd3, 4'd3, 8'hFF);
        check("reset_do1", do1, 8'h00);
        check("reset_do2", do2, 8'h00);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, ram_addr_t'(i), ram_addr_t'(15 - i), 8'h00);
            check($sformatf("reset_rd1_%0d", i), do1, 8'h00);
            check($sformatf("reset_rd2_%0d", 15 - i), do2, 8'h00);
        end

        // Fill and readback on both ports.
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 1, ram_addr_t'(i), 4'd0, 8'(i) ^ 8'hA5);
            check($sformatf("fill_do1_%0d", i), do1, 8'(i) ^ 8'hA5);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, 4'd0, ram_addr_t'(i), 8'h00);
            check($sformatf("sweep_do2_%0d", i), do2, 8'(i) ^ 8'hA5);
        end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 0, ram_addr_t'(i), 4'd0, 8'h00);
            check($sformatf("sweep_do1_%0d", i), do1, 8'(i) ^ 8'hA5);
        end

        // Enable gating: outputs hold and the blocked write never lands.
        cycle(0, 1, 1, 4'd5, 4'd2, 8'h3C);
        check("gate_store", do1, 8'h3C);
        check("gate_do2_pre", do2, 8'h02 ^ 8'hA5);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 4'd5, 4'd5, 8'h99);
            check($sformatf("gate_hold1_%0d", i), do1, 8'h3C);
            check($sformatf("gate_hold2_%0d", i), do2, 8'h02 ^ 8'hA5);
        end
        cycle(0, 1, 0, 4'd5, 4'd5, 8'h00);
        check("gate_rd1", do1, 8'h3C);
        check("gate_rd2", do2, 8'h3C);

        // Collision bypass on port 2.
        cycle(0, 1, 1, 4'd7, 4'd0, 8'h11);
        cycle(0, 1, 1, 4'd7, 4'd7, 8'h5A);
        check("coll_do1", do1, 8'h5A);
        check("coll_do2", do2, 8'h5A);
        cycle(0, 1, 0, 4'd7, 4'd7, 8'h00);
        check("coll_rd1", do1, 8'h5A);
        check("coll_rd2", do2, 8'h5A);

        // Independent ports.
        cycle(0, 1, 1, 4'd12, 4'd0, 8'h21);
        cycle(0, 1, 1, 4'd3, 4'd12, 8'hC3);
        check("indep_do1", do1, 8'hC3);
        check("indep_do2", do2, 8'h21);
        cycle(0, 1, 0, 4'd0, 4'd3, 8'h00);
        check("indep_rd2", do2, 8'hC3);

        // Mid-operation reset during a fill.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, ram_addr_t'(i), 4'd15, 8'h40 + 8'(i));
        end
        cycle(1, 1, 1, 4'd9, 4'd9, 8'h77);
        check("midrst_do1", do1, 8'h00);
        check("midrst_do2", do2, 8'h00);
        cycle(0, 1, 0, 4'd9, 4'd9, 8'h00);
        check("midrst_rd9", do1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, ram_addr_t'(i), ram_addr_t'(i), 8'h00);
            check($sformatf("midrst_cleared_%0d", i), do2, 8'h00);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  ram_addr_t'($urandom),
                  ($urandom_range(0, 3) == 0) ? add1 : ram_addr_t'($urandom),
                  ram_data_t'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
